// File: rtl/arith_carry_pkg.sv
// Shared types for the arithmetic-coder carry resolver: FSM states, the
// pre-carry word layout and the carry-add helper.
package arith_carry_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HOLD       = 3'd1,
    EMIT_H     = 3'd2,
    EMIT_RUN   = 3'd3,
    FLUSH_WAIT = 3'd4
  } carry_state_t;

  localparam int         CARRY_BIT = 8;
  localparam logic [7:0] BYTE_FF   = 8'hFF;

  typedef struct packed {
    logic       carry;
    logic [7:0] data;
  } precarry_t;

  function automatic logic [7:0] add_carry(input logic [7:0] b, input logic c);
    return b + {7'd0, c};
  endfunction

endpackage

// File: rtl/arith_carry_resolver.sv
// Resolves encoder carries with a held byte plus a pending 0xFF run and emits
// final bytes over valid/ready. Optional stat_bytes counter: ARITH_CARRY_STATS_EN.
module arith_carry_resolver
  import arith_carry_pkg::*;
#(
  parameter int RUN_CNT_WIDTH = 16,
  parameter int IN_WIDTH      = 9,
  parameter int STATS_WIDTH   = 32
) (
  input  logic                general_clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_byte,
  output logic                out_last,
  output logic [1:0]          err,
  output logic                busy
`ifdef ARITH_CARRY_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] stat_bytes
`endif
);

  localparam logic [RUN_CNT_WIDTH-1:0] RUN_ZERO = {RUN_CNT_WIDTH{1'b0}};
  localparam logic [RUN_CNT_WIDTH-1:0] RUN_ONE  = {{(RUN_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RUN_CNT_WIDTH-1:0] RUN_MAX  = {RUN_CNT_WIDTH{1'b1}};

  carry_state_t             r_state, w_nxt_state;
  logic [7:0]               r_h, w_nxt_h;
  logic [7:0]               r_stage, w_nxt_stage;
  logic [RUN_CNT_WIDTH-1:0] r_run, w_nxt_run;
  logic                     r_c_pend, w_nxt_c_pend;
  logic                     r_last_pend, w_nxt_last_pend;
  logic                     r_flush_pend, w_nxt_flush_pend;
  logic [1:0]               r_err, w_nxt_err;
  logic                     r_in_ready, r_out_valid, r_out_last, r_busy;
  logic [7:0]               r_out_byte;
  logic                     w_nxt_out_valid, w_nxt_out_last;
  logic [7:0]               w_nxt_out_byte;
  logic                     w_accept, w_is_ff, w_drain_done;
  precarry_t                w_in;

  assign w_in     = '{carry: in_data[CARRY_BIT], data: in_data[7:0]};
  assign w_accept = in_valid && r_in_ready;
  assign w_is_ff  = !w_in.carry && (w_in.data == BYTE_FF);

  // Next-state logic: accept/absorb words, drain held byte and 0xFF run.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_h          = r_h;
    w_nxt_stage      = r_stage;
    w_nxt_run        = r_run;
    w_nxt_c_pend     = r_c_pend;
    w_nxt_last_pend  = r_last_pend;
    w_nxt_flush_pend = r_flush_pend;
    w_nxt_err        = r_err;
    w_drain_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nxt_h         = w_in.data;
          w_nxt_err[0]    = r_err[0] | w_in.carry;
          w_nxt_c_pend    = 1'b0;
          w_nxt_last_pend = flush;
          w_nxt_state     = flush ? EMIT_H : HOLD;
        end else begin
          w_nxt_state = IDLE;
        end
      end
      HOLD: begin
        if (w_accept && w_is_ff) begin
          if (r_run == RUN_MAX) begin
            w_nxt_err[1] = 1'b1;
          end else begin
            w_nxt_run = r_run + RUN_ONE;
          end
          w_nxt_c_pend    = 1'b0;
          w_nxt_last_pend = flush;
          w_nxt_state     = flush ? EMIT_H : HOLD;
        end else if (w_accept) begin
          // Word is parked in staging; a simultaneous flush resumes after the drain.
          w_nxt_c_pend     = w_in.carry;
          w_nxt_stage      = w_in.data;
          w_nxt_flush_pend = flush;
          w_nxt_state      = EMIT_H;
        end else if (flush) begin
          w_nxt_c_pend    = 1'b0;
          w_nxt_last_pend = 1'b1;
          w_nxt_state     = EMIT_H;
        end else begin
          w_nxt_state = HOLD;
        end
      end
      EMIT_H: begin
        if (out_ready && (r_run != RUN_ZERO)) begin
          w_nxt_state = EMIT_RUN;
        end else if (out_ready) begin
          w_drain_done = 1'b1;
        end else begin
          w_nxt_state = EMIT_H;
        end
      end
      EMIT_RUN: begin
        if (out_ready) begin
          w_nxt_run    = r_run - RUN_ONE;
          w_drain_done = (r_run == RUN_ONE);
        end else begin
          w_nxt_state = EMIT_RUN;
        end
      end
      FLUSH_WAIT: begin
        w_nxt_c_pend     = 1'b0;
        w_nxt_last_pend  = 1'b1;
        w_nxt_flush_pend = 1'b0;
        w_nxt_state      = EMIT_H;
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
    case ({w_drain_done, r_last_pend})
      2'b11: begin
        w_nxt_c_pend    = 1'b0;
        w_nxt_last_pend = 1'b0;
        w_nxt_state     = IDLE;
      end
      2'b10: begin
        w_nxt_h          = r_stage;
        w_nxt_c_pend     = 1'b0;
        w_nxt_flush_pend = 1'b0;
        w_nxt_state      = r_flush_pend ? FLUSH_WAIT : HOLD;
      end
      default: begin
      end
    endcase
  end

  // Output values derived from the next state so they are registered in step.
  always_comb begin
    w_nxt_out_valid = (w_nxt_state == EMIT_H) || (w_nxt_state == EMIT_RUN);
    case (w_nxt_state)
      EMIT_H:   w_nxt_out_byte = add_carry(w_nxt_h, w_nxt_c_pend);
      EMIT_RUN: w_nxt_out_byte = w_nxt_c_pend ? 8'h00 : BYTE_FF;
      default:  w_nxt_out_byte = 8'h00;
    endcase
    w_nxt_out_last = w_nxt_last_pend &&
                     (((w_nxt_state == EMIT_H) && (w_nxt_run == RUN_ZERO)) ||
                      ((w_nxt_state == EMIT_RUN) && (w_nxt_run == RUN_ONE)));
  end

  // State and registered outputs.
  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_h          <= 8'h00;
      r_stage      <= 8'h00;
      r_run        <= RUN_ZERO;
      r_c_pend     <= 1'b0;
      r_last_pend  <= 1'b0;
      r_flush_pend <= 1'b0;
      r_err        <= 2'b00;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_byte   <= 8'h00;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_h          <= w_nxt_h;
      r_stage      <= w_nxt_stage;
      r_run        <= w_nxt_run;
      r_c_pend     <= w_nxt_c_pend;
      r_last_pend  <= w_nxt_last_pend;
      r_flush_pend <= w_nxt_flush_pend;
      r_err        <= w_nxt_err;
      r_in_ready   <= (w_nxt_state == IDLE) || (w_nxt_state == HOLD);
      r_out_valid  <= w_nxt_out_valid;
      r_out_byte   <= w_nxt_out_byte;
      r_out_last   <= w_nxt_out_last;
      r_busy       <= (w_nxt_state != IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_byte  = r_out_byte;
  assign out_last  = r_out_last;
  assign err       = r_err;
  assign busy      = r_busy;

`ifdef ARITH_CARRY_STATS_EN
  logic [STATS_WIDTH-1:0] r_stat;

  // Saturating count of output handshakes.
  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      r_stat <= {STATS_WIDTH{1'b0}};
    end else if (r_out_valid && out_ready && (r_stat != {STATS_WIDTH{1'b1}})) begin
      r_stat <= r_stat + {{(STATS_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_stat <= r_stat;
    end
  end

  assign stat_bytes = r_stat;
`endif

endmodule
